freq_divider_n: RTL and testbench
=================================

// Module: freq_divider_n
// PURPOSE
//  Multi-channel programmable frequency divider for the system clock domain. A shared
//  power-of-two prescaler feeds N independent modulo-D channels; each channel emits a
//  one-clk tick (clock enable) and a near-50% square wave, both synchronous to clk.
//  Generates slow rates for display scan, sampling and tone logic without derived clocks.
// PARAMETERS
//  N_CH      2    number of divider channels
//  PRE_BITS  13   prescaler width; pre_tick every 2^PRE_BITS clk (0 => every clk)
//  DIV_W     8    divisor width per channel
//  DEF_DIV   13   divisor loaded into every channel at reset (must fit DIV_W)
// PORTS
//  clk     in   1            system clock
//  rst     in   1            asynchronous reset, active-high
//  en_i    in   N_CH         per-channel run enable
//  load_i  in   N_CH         per-channel divisor load strobe (1 clk)
//  div_i   in   N_CH*DIV_W   divisor values, ch k in [k*DIV_W +: DIV_W]
//  tick_o  out  N_CH         one-clk pulse once per output period
//  sq_o    out  N_CH         square wave, high for first ceil(D/2) counts of period
//  pend_o  out  N_CH         loaded divisor waiting to take effect
// BEHAVIOUR
//  - Reset (async, any time): prescaler=0, cnt=0, active D=DEF_DIV, pending cleared;
//    tick_o=0, sq_o=0, pend_o=0. Operation resumes on first clk edge after release.
//  - Prescaler: free-running PRE_BITS counter; pre_tick=1 when count is all ones.
//  - Channel, per pre_tick while en_i=1 and D>=1: cnt wraps to 0 when cnt==D-1,
//    else cnt+1. Output period = D*2^PRE_BITS clk. All outputs registered.
//  - tick_o=1 for exactly the clk cycle after the pre_tick on which cnt wrapped.
//  - sq_o registered from next cnt: 1 when cnt_next < (D+1)>>1. D odd => high one
//    count longer than low. D=1 => sq_o constant 1, tick every pre_tick.
//  - D=0: channel idle; cnt held 0, tick_o=0, sq_o=0.
//  - load_i: div_i captured into shadow, pend_o=1 next clk. Shadow becomes active D
//    at the next wrap, or immediately if channel idle (en_i=0 or D=0); pend_o clears then.
//    Load in same cycle as a wrap: new value applied at that wrap, no pend_o pulse.
//    Second load while pending: shadow overwritten, last value wins.
//  - en_i=0: cnt cleared to 0, tick_o=0, sq_o=0 on next clk; re-enable restarts at cnt 0.
//  - Channels fully independent; only the prescaler is shared.
// CONFIGURATION
//  FREQ_DIV_SYNC_EN defined: extra input sync_i (1 bit). sync_i=1 for one clk clears
//   prescaler and all channel counters to 0, applies all pending divisors, forces
//   tick_o=0 that cycle; all channels then run phase-aligned. sync_i beats load/wrap.
//  Not defined: port absent, behaviour identical to sync_i tied 0.
// STRUCTURE
//  Package freq_div_pkg: DIV_W default, DEF_DIV default, channel state struct
//   {cnt, active_div, shadow_div, pend}, helper for half = (D+1)>>1.
//  Sub-module freq_div_channel: one channel (counter, shadow, tick/sq regs), inputs
//   pre_tick, en, load, div, sync; instantiated N_CH times by generate loop.
//  Top holds prescaler and port slicing only.
// TESTING (bench params: N_CH=2, PRE_BITS=2, DIV_W=4, DEF_DIV=13)
//  1 Reset/default: release rst, en_i=11 -> tick_o every 52 clk; sq_o high 28, low 24.
//  2 Mid-run rst pulse between clk edges -> all outputs 0 at once; after release
//    first tick at 52 clk, pending load lost.
//  3 Load D=5 on ch0 at cnt=3 -> pend_o=1; current 52-clk period completes, then
//    tick every 20 clk, sq_o 12 high/8 low; ch1 unchanged at 52.
//  4 Load D=5 coincident with wrap -> next period already 20 clk, pend_o stays 0;
//    two loads (7 then 9) while pending -> 36-clk period after wrap.
//  5 D=0 -> tick_o, sq_o 0; D=1 -> tick every 4 clk, sq_o constant 1; en_i=0 on ch1
//    -> ch1 outputs 0 next clk, ch0 period unaffected.
//  6 FREQ_DIV_SYNC_EN: ch0 D=4, ch1 D=8 offset, sync_i pulse -> no tick that cycle,
//    ch0 and ch1 ticks coincide every 32 clk thereafter.

Source files
------------

// File: rtl/freq_div_pkg.sv
// Shared types and helpers for the multi-channel frequency divider.
package freq_div_pkg;

  localparam int DIV_W_DEF   = 8;
  localparam int DEF_DIV_DEF = 13;
  localparam int DIV_W_MAX   = 16;

  typedef logic [DIV_W_MAX-1:0] div_t;

  typedef struct packed {
    div_t cnt;
    div_t active_div;
    div_t shadow_div;
    logic pend;
  } ch_state_t;

  // Number of counts the square wave stays high: (D+1)>>1, carry kept so D=max is safe.
  function automatic div_t half_div(input div_t d);
    logic [DIV_W_MAX:0] s;
    s = {1'b0, d} + (DIV_W_MAX+1)'(1);
    return s[DIV_W_MAX:1];
  endfunction

endpackage

// File: rtl/freq_div_channel.sv
// One modulo-D divider channel: counter, shadow divisor, registered tick and square wave.
module freq_div_channel
  import freq_div_pkg::*;
#(
  parameter int DIV_W   = DIV_W_DEF,
  parameter int DEF_DIV = DEF_DIV_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pre_tick,
  input  logic             en,
  input  logic             load,
  input  logic [DIV_W-1:0] div,
  input  logic             sync,
  output logic             tick,
  output logic             sq,
  output logic             pend
);

  ch_state_t st, st_nxt;
  logic      tick_nxt, sq_nxt;
  logic      idle, wrap, apply;
  div_t      div_ext;

  assign div_ext = div_t'(div);
  assign idle    = !en || (st.active_div == '0);
  assign wrap    = pre_tick && !idle && (st.cnt == st.active_div - div_t'(1));
  // A new divisor may only take effect at a period boundary or when nothing is counting.
  assign apply   = wrap || idle || sync;

  always_comb begin
    st_nxt = st;
    if (idle || sync) begin
      st_nxt.cnt = '0;
    end else if (pre_tick) begin
      st_nxt.cnt = wrap ? '0 : st.cnt + div_t'(1);
    end

    if (load) begin
      st_nxt.shadow_div = div_ext;
      if (apply) begin
        st_nxt.active_div = div_ext;
        st_nxt.pend       = 1'b0;
      end else begin
        st_nxt.pend       = 1'b1;
      end
    end else if (st.pend && apply) begin
      st_nxt.active_div = st.shadow_div;
      st_nxt.pend       = 1'b0;
    end

    tick_nxt = wrap && !sync;
    sq_nxt   = en && (st_nxt.active_div != '0) &&
               (st_nxt.cnt < half_div(st_nxt.active_div));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st.cnt        <= '0;
      st.active_div <= div_t'(DEF_DIV);
      st.shadow_div <= div_t'(DEF_DIV);
      st.pend       <= 1'b0;
      tick          <= 1'b0;
      sq            <= 1'b0;
    end else begin
      st   <= st_nxt;
      tick <= tick_nxt;
      sq   <= sq_nxt;
    end
  end

  assign pend = st.pend;

endmodule

// File: rtl/freq_divider_n.sv
// Multi-channel programmable frequency divider: shared power-of-two prescaler feeding
// N_CH modulo-D channels. Define FREQ_DIV_SYNC_EN to add the sync_i phase-align input.
module freq_divider_n
  import freq_div_pkg::*;
#(
  parameter int N_CH     = 2,
  parameter int PRE_BITS = 13,
  parameter int DIV_W    = DIV_W_DEF,
  parameter int DEF_DIV  = DEF_DIV_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       en_i,
  input  logic [N_CH-1:0]       load_i,
  input  logic [N_CH*DIV_W-1:0] div_i,
`ifdef FREQ_DIV_SYNC_EN
  input  logic                  sync_i,
`endif
  output logic [N_CH-1:0]       tick_o,
  output logic [N_CH-1:0]       sq_o,
  output logic [N_CH-1:0]       pend_o
);

  logic pre_tick;
  logic sync;

`ifdef FREQ_DIV_SYNC_EN
  assign sync = sync_i;
`else
  assign sync = 1'b0;
`endif

  generate
    if (PRE_BITS == 0) begin : g_no_pre
      assign pre_tick = 1'b1;
    end else begin : g_pre
      logic [PRE_BITS-1:0] pre_cnt;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          pre_cnt <= '0;
        end else if (sync) begin
          pre_cnt <= '0;
        end else begin
          pre_cnt <= pre_cnt + PRE_BITS'(1);
        end
      end

      assign pre_tick = &pre_cnt;
    end
  endgenerate

  generate
    for (genvar k = 0; k < N_CH; k++) begin : g_ch
      freq_div_channel #(
        .DIV_W   (DIV_W),
        .DEF_DIV (DEF_DIV)
      ) u_ch (
        .clk      (clk),
        .rst      (rst),
        .pre_tick (pre_tick),
        .en       (en_i[k]),
        .load     (load_i[k]),
        .div      (div_i[k*DIV_W +: DIV_W]),
        .sync     (sync),
        .tick     (tick_o[k]),
        .sq       (sq_o[k]),
        .pend     (pend_o[k])
      );
    end
  endgenerate

endmodule

// File: tb/tb_freq_divider_n.sv
// Self-checking bench for freq_divider_n: directed period checks plus randomized
// stimulus compared every cycle against a behavioural divider model.
module tb_freq_divider_n;

  localparam int N_CH     = 2;
  localparam int PRE_BITS = 2;
  localparam int DIV_W    = 4;
  localparam int DEF_DIV  = 13;
  localparam int PRE_N    = 1 << PRE_BITS;
  localparam int DW_ALL   = N_CH * DIV_W;

  logic              clk;
  logic              rst;
  logic [N_CH-1:0]   en_i;
  logic [N_CH-1:0]   load_i;
  logic [DW_ALL-1:0] div_i;
  logic              sync_i;
  logic [N_CH-1:0]   tick_o, sq_o, pend_o;

  int n_vec = 0;
  int n_err = 0;
  bit mon_on = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  freq_divider_n #(
    .N_CH(N_CH), .PRE_BITS(PRE_BITS), .DIV_W(DIV_W), .DEF_DIV(DEF_DIV)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .en_i   (en_i),
    .load_i (load_i),
    .div_i  (div_i),
`ifdef FREQ_DIV_SYNC_EN
    .sync_i (sync_i),
`endif
    .tick_o (tick_o),
    .sq_o   (sq_o),
    .pend_o (pend_o)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: pre_tick count modulo D, divisor swap only at period boundary or idle.
  int m_pre;
  int m_cnt [N_CH];
  int m_d   [N_CH];
  int m_sh  [N_CH];
  bit m_pend[N_CH];
  bit m_tick[N_CH];
  bit m_sq  [N_CH];

  task automatic model_reset();
    m_pre = 0;
    for (int k = 0; k < N_CH; k++) begin
      m_cnt[k] = 0; m_d[k] = DEF_DIV; m_sh[k] = DEF_DIV;
      m_pend[k] = 0; m_tick[k] = 0; m_sq[k] = 0;
    end
  endtask

  task automatic model_step();
    bit pre, run, wrapped, apply, sy;
    int dv;
    pre = (m_pre == PRE_N - 1);
    sy  = (sync_i === 1'b1);
`ifndef FREQ_DIV_SYNC_EN
    sy  = 0;
`endif
    m_pre = sy ? 0 : (m_pre + 1) % PRE_N;
    for (int k = 0; k < N_CH; k++) begin
      dv      = int'(div_i[k*DIV_W +: DIV_W]);
      run     = en_i[k] && (m_d[k] > 0);
      wrapped = run && pre && ((m_cnt[k] + 1) % m_d[k] == 0);
      if (!run || sy) m_cnt[k] = 0;
      else if (pre)   m_cnt[k] = (m_cnt[k] + 1) % m_d[k];
      apply = wrapped || !run || sy;
      if (load_i[k]) begin
        m_sh[k]   = dv;
        m_pend[k] = !apply;
      end
      if (apply && (load_i[k] || m_pend[k])) begin
        m_d[k]    = m_sh[k];
        m_pend[k] = 0;
      end
      m_tick[k] = wrapped && !sy;
      m_sq[k]   = en_i[k] && (m_d[k] > 0) && (m_cnt[k] < (m_d[k] + 1) / 2);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (mon_on && !rst) begin
        for (int k = 0; k < N_CH; k++) begin
          chk($sformatf("tick%0d", k), int'(tick_o[k]), int'(m_tick[k]));
          chk($sformatf("sq%0d", k),   int'(sq_o[k]),   int'(m_sq[k]));
          chk($sformatf("pend%0d", k), int'(pend_o[k]), int'(m_pend[k]));
        end
      end
    end
  end

  task automatic wait_tick(input int ch, input int limit, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!tick_o[ch] && cyc < limit);
    if (!tick_o[ch]) chk($sformatf("tick_timeout%0d", ch), 0, 1);
  endtask

  task automatic measure(input int ch, input int exp_per, input int exp_hi);
    int c, per, hi;
    wait_tick(ch, 300, c);
    per = 0;
    hi  = 0;
    do begin
      if (sq_o[ch]) hi++;
      @(negedge clk);
      per++;
    end while (!tick_o[ch] && per < 300);
    chk($sformatf("period%0d", ch), per, exp_per);
    chk($sformatf("high%0d", ch), hi, exp_hi);
  endtask

  task automatic do_load(input int ch, input int d);
    div_i[ch*DIV_W +: DIV_W] = DIV_W'(d);
    load_i[ch] = 1'b1;
    @(negedge clk);
    load_i[ch] = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, nt, ns;
    rst = 1'b1; en_i = '1; load_i = '0; div_i = '0; sync_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tick", int'(tick_o), 0);
    chk("rst_sq",   int'(sq_o),   0);
    chk("rst_pend", int'(pend_o), 0);
    rst = 1'b0;
    mon_on = 1;

    // Default divisor after reset
    wait_tick(0, 200, c);
    chk("first_tick0", c, 52);
    chk("first_tick1_aligned", int'(tick_o[1]), 1);
    measure(0, 52, 28);
    measure(1, 52, 28);

    // Load mid-period: current period finishes first
    wait_tick(0, 200, c);
    repeat (13) @(negedge clk);
    do_load(0, 5);
    chk("t3_pend", int'(pend_o[0]), 1);
    wait_tick(0, 200, c);
    chk("t3_rest", c, 38);
    measure(0, 20, 12);
    measure(1, 52, 28);

    // Load coincident with wrap, then back-to-back loads while pending
    wait_tick(1, 200, c);
    repeat (51) @(negedge clk);
    do_load(1, 5);
    chk("t4_wrap_tick", int'(tick_o[1]), 1);
    chk("t4_wrap_pend", int'(pend_o[1]), 0);
    measure(1, 20, 12);
    repeat (5) @(negedge clk);
    do_load(1, 7);
    do_load(1, 9);
    chk("t4_pend2", int'(pend_o[1]), 1);
    measure(1, 36, 20);

    // D=0 idle, D=1 every prescaler tick, disabling ch1 leaves ch0 alone
    en_i[0] = 1'b0;
    @(negedge clk);
    chk("t5_dis_tick", int'(tick_o[0]), 0);
    chk("t5_dis_sq",   int'(sq_o[0]),   0);
    do_load(0, 0);
    en_i[0] = 1'b1;
    nt = 0; ns = 0;
    repeat (60) begin
      @(negedge clk);
      nt += int'(tick_o[0]);
      ns += int'(sq_o[0]);
    end
    chk("t5_d0_ticks", nt, 0);
    chk("t5_d0_sq", ns, 0);
    do_load(0, 1);
    measure(0, 4, 4);
    en_i[1] = 1'b0;
    @(negedge clk);
    chk("t5_ch1_off_tick", int'(tick_o[1]), 0);
    chk("t5_ch1_off_sq",   int'(sq_o[1]),   0);
    measure(0, 4, 4);
    en_i[1] = 1'b1;

    // Asynchronous reset between edges discards a pending load
    wait_tick(1, 200, c);
    repeat (2) @(negedge clk);
    do_load(1, 3);
    chk("t2_pend_before", int'(pend_o[1]), 1);
    #2 rst = 1'b1;
    #1;
    chk("t2_async_tick", int'(tick_o), 0);
    chk("t2_async_sq",   int'(sq_o),   0);
    chk("t2_async_pend", int'(pend_o), 0);
    @(negedge clk);
    rst = 1'b0;
    wait_tick(1, 200, c);
    chk("t2_first_tick1", c, 52);
    chk("t2_first_tick0", int'(tick_o[0]), 1);
    measure(1, 52, 28);

    // Randomized traffic checked cycle by cycle against the model
    repeat (500) begin
      for (int k = 0; k < N_CH; k++) begin
        en_i[k]   = ($urandom_range(7) != 0);
        load_i[k] = ($urandom_range(11) == 0);
      end
      div_i = DW_ALL'($urandom);
      @(negedge clk);
    end
    load_i = '0;
    en_i   = '1;
    repeat (10) @(negedge clk);

`ifdef FREQ_DIV_SYNC_EN
    en_i = '0;
    @(negedge clk);
    do_load(0, 4);
    do_load(1, 8);
    en_i[0] = 1'b1;
    repeat (7) @(negedge clk);
    en_i[1] = 1'b1;
    repeat (21) @(negedge clk);
    sync_i = 1'b1;
    @(negedge clk);
    sync_i = 1'b0;
    chk("t6_sync_tick", int'(tick_o), 0);
    wait_tick(1, 200, c);
    chk("t6_first_tick1", c, 32);
    chk("t6_align_a", int'(tick_o[0]), 1);
    wait_tick(1, 200, c);
    chk("t6_period1", c, 32);
    chk("t6_align_b", int'(tick_o[0]), 1);
`endif

    mon_on = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
